// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch-side program counter owner.
// Sequences sequential fetch, hazard stalls and taken-branch redirects.
// After an accepted redirect, Flush is held for FLUSH_CYCLES cycles to drain
// wrong-path instructions. Malformed targets raise one-cycle error pulses,
// and accepted redirects are counted with a saturating counter.
module pc_redirect_unit #(
  parameter int unsigned PC_W         = 9,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            Stall,
  output logic [PC_W-1:0] Cur_PC,
  output logic            Flush,
  output logic            Misalign_Err,
  output logic            Range_Err,
  output logic [15:0]     Redirect_Count
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [PC_W-1:0] PC_RESET   = RESET_PC[PC_W-1:0];
  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
  localparam logic [2:0]      FLUSH_INIT = 3'(FLUSH_CYCLES);

  logic [0:0]      state_q, state_d;
  logic [2:0]      fcnt_q, fcnt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            flush_q, flush_d;
  logic            mis_q, mis_d;
  logic            rng_q, rng_d;
  logic [15:0]     count_q, count_d;

  // Next sequential fetch address; the adder width gives the modulo-2^PC_W wrap.
  function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

  // Redirect target truncated to PC_W bits and forced to word alignment.
  function automatic logic [PC_W-1:0] align_target(input logic [31:0] br);
    return {br[PC_W-1:2], 2'b00};
  endfunction

  // Saturating increment so the count never wraps back to zero.
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // Next-state logic: redirect beats stall in RUN; FLUSH ignores PcSel/Stall.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    mis_d   = 1'b0;
    rng_d   = 1'b0;
    count_d = count_q;
    case (state_q)
      ST_RUN: begin
        if (PcSel) begin
          pc_d    = align_target(BrPC);
          flush_d = 1'b1;
          fcnt_d  = FLUSH_INIT;
          state_d = ST_FLUSH;
          mis_d   = |BrPC[1:0];
          rng_d   = |BrPC[31:PC_W];
          count_d = sat_inc(count_q);
        end else if (Stall) begin
          pc_d = pc_q;
        end else begin
          pc_d = seq_pc(pc_q);
        end
      end
      ST_FLUSH: begin
        pc_d = seq_pc(pc_q);
        if (fcnt_q <= 3'd1) begin
          fcnt_d  = 3'd0;
          flush_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          fcnt_d  = fcnt_q - 3'd1;
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
        fcnt_d  = 3'd0;
        flush_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      fcnt_q  <= 3'd0;
      pc_q    <= PC_RESET;
      flush_q <= 1'b0;
      mis_q   <= 1'b0;
      rng_q   <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      mis_q   <= mis_d;
      rng_q   <= rng_d;
      count_q <= count_d;
    end
  end

  assign Cur_PC         = pc_q;
  assign Flush          = flush_q;
  assign Misalign_Err   = mis_q;
  assign Range_Err      = rng_q;
  assign Redirect_Count = count_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit (PC_W=9, RESET_PC=0, FLUSH_CYCLES=2).
module tb_pc_redirect_unit;

  logic        clk;
  logic        reset;
  logic        PcSel;
  logic [31:0] BrPC;
  logic        Stall;
  logic [8:0]  Cur_PC;
  logic        Flush;
  logic        Misalign_Err;
  logic        Range_Err;
  logic [15:0] Redirect_Count;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers, flush cycles remaining.
  int m_pc;
  int m_left;
  int m_cnt;
  bit m_mis;
  bit m_rng;

  pc_redirect_unit #(
    .PC_W(9),
    .RESET_PC(32'h0000_0000),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .PcSel(PcSel),
    .BrPC(BrPC),
    .Stall(Stall),
    .Cur_PC(Cur_PC),
    .Flush(Flush),
    .Misalign_Err(Misalign_Err),
    .Range_Err(Range_Err),
    .Redirect_Count(Redirect_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          pcsel;
    bit          stall;
    logic [31:0] br;
    logic [8:0]  e_pc;
    bit          e_flush;
    bit          e_mis;
    bit          e_rng;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [8:0] pc, input bit fl,
                         input bit mis, input bit rng, input logic [15:0] cnt);
    chk({tag, ".pc"}, {23'd0, Cur_PC}, {23'd0, pc});
    chk({tag, ".flush"}, {31'd0, Flush}, {31'd0, fl});
    chk({tag, ".mis"}, {31'd0, Misalign_Err}, {31'd0, mis});
    chk({tag, ".rng"}, {31'd0, Range_Err}, {31'd0, rng});
    chk({tag, ".cnt"}, {16'd0, Redirect_Count}, {16'd0, cnt});
  endtask

  task automatic model_reset();
    m_pc = 0; m_left = 0; m_cnt = 0; m_mis = 0; m_rng = 0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_edge(input bit ps, input bit st, input logic [31:0] br);
    m_mis = 0;
    m_rng = 0;
    if (m_left > 0) begin
      m_pc = (m_pc + 4) % 512;
      m_left = m_left - 1;
    end else if (ps) begin
      m_pc = (br % 512) - (br % 4);
      m_left = 2;
      m_mis = (br % 4) != 0;
      m_rng = br >= 32'd512;
      m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    end else if (!st) begin
      m_pc = (m_pc + 4) % 512;
    end
  endtask

  // Drive inputs at negedge, clock once, update model, check at next negedge.
  task automatic step_model(input string tag, input bit ps, input bit st, input logic [31:0] br);
    PcSel = ps; Stall = st; BrPC = br;
    @(posedge clk);
    model_edge(ps, st, br);
    @(negedge clk);
    chk_all(tag, 9'(m_pc), m_left > 0, m_mis, m_rng, 16'(m_cnt));
  endtask

  initial begin
    vecs[0]  = '{0, 0, 32'h0,     9'h004, 0, 0, 0, 16'd0};
    vecs[1]  = '{0, 0, 32'h0,     9'h008, 0, 0, 0, 16'd0};
    vecs[2]  = '{0, 0, 32'h0,     9'h00C, 0, 0, 0, 16'd0};
    vecs[3]  = '{0, 0, 32'h0,     9'h010, 0, 0, 0, 16'd0};
    vecs[4]  = '{1, 0, 32'h40,    9'h040, 1, 0, 0, 16'd1};
    vecs[5]  = '{1, 0, 32'h100,   9'h044, 1, 0, 0, 16'd1};
    vecs[6]  = '{1, 1, 32'h120,   9'h048, 0, 0, 0, 16'd1};
    vecs[7]  = '{0, 1, 32'h0,     9'h048, 0, 0, 0, 16'd1};
    vecs[8]  = '{0, 1, 32'h0,     9'h048, 0, 0, 0, 16'd1};
    vecs[9]  = '{0, 1, 32'h0,     9'h048, 0, 0, 0, 16'd1};
    vecs[10] = '{1, 1, 32'h80,    9'h080, 1, 0, 0, 16'd2};
    vecs[11] = '{0, 0, 32'h0,     9'h084, 1, 0, 0, 16'd2};
    vecs[12] = '{0, 0, 32'h0,     9'h088, 0, 0, 0, 16'd2};
    vecs[13] = '{1, 0, 32'hA46,   9'h044, 1, 1, 1, 16'd3};
    vecs[14] = '{0, 0, 32'h0,     9'h048, 1, 0, 0, 16'd3};
    vecs[15] = '{0, 0, 32'h0,     9'h04C, 0, 0, 0, 16'd3};
    vecs[16] = '{1, 0, 32'h1F8,   9'h1F8, 1, 0, 0, 16'd4};
    vecs[17] = '{0, 0, 32'h0,     9'h1FC, 1, 0, 0, 16'd4};
    vecs[18] = '{0, 0, 32'h0,     9'h000, 0, 0, 0, 16'd4};
    vecs[19] = '{1, 0, 32'h0,     9'h000, 1, 0, 0, 16'd5};
    vecs[20] = '{0, 0, 32'h0,     9'h004, 1, 0, 0, 16'd5};
    vecs[21] = '{0, 0, 32'h0,     9'h008, 0, 0, 0, 16'd5};
    vecs[22] = '{1, 0, 32'h1F6,   9'h1F4, 1, 1, 0, 16'd6};
    vecs[23] = '{1, 0, 32'h0,     9'h1F8, 1, 0, 0, 16'd6};
    vecs[24] = '{0, 0, 32'h0,     9'h1FC, 0, 0, 0, 16'd6};
    vecs[25] = '{0, 0, 32'h0,     9'h000, 0, 0, 0, 16'd6};

    reset = 1'b1; PcSel = 1'b0; Stall = 1'b0; BrPC = 32'h0;
    #2;
    chk_all("reset", 9'h000, 0, 0, 0, 16'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed table: sequential fetch, branch, stall, malformed target, wrap.
    for (int i = 0; i < 26; i++) begin
      PcSel = vecs[i].pcsel; Stall = vecs[i].stall; BrPC = vecs[i].br;
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_flush,
              vecs[i].e_mis, vecs[i].e_rng, vecs[i].e_cnt);
    end

    // Reset asserted between edges in the first FLUSH cycle.
    PcSel = 1'b1; BrPC = 32'h0000_0100; Stall = 1'b0;
    @(posedge clk);
    #2;
    PcSel = 1'b0;
    chk("midflush.pre_flush", {31'd0, Flush}, 32'd1);
    reset = 1'b1;
    #1;
    chk_all("midflush.reset", 9'h000, 0, 0, 0, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_all("midflush.resume", 9'h004, 0, 0, 0, 16'd0);
    @(negedge clk);
    chk_all("midflush.resume2", 9'h008, 0, 0, 0, 16'd0);

    // Randomized stimulus against the model, starting from a fresh reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] br;
      bit ps, st;
      ps = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      step_model("rand", ps, st, br);
    end

    // Saturation: preload the counter near full, then keep redirecting.
    for (int i = 0; i < 3; i++) step_model("sat_idle", 0, 0, 32'h0);
    force dut.count_q = 16'hFFFB;
    #1;
    release dut.count_q;
    m_cnt = 65531;
    for (int i = 0; i < 18; i++) step_model("sat", 1, 0, 32'h0000_0020);
    chk("sat.final", {16'd0, Redirect_Count}, 32'h0000_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
